// File: rtl/alu_gate_pipe.sv
// rtl/alu_gate_pipe.sv - pipelined logic-op unit with valid/ready backpressure
module alu_gate_pipe #(
    parameter int DATA_WIDTH = 32,
    parameter int PIPE_DEPTH = 2,
    parameter int TAG_WIDTH  = 5
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             in_valid_i,
    output logic                             in_ready_o,
    input  logic [2:0]                       op_i,
    input  logic [DATA_WIDTH-1:0]            rs1_data_i,
    input  logic [DATA_WIDTH-1:0]            rs2_data_i,
    input  logic [TAG_WIDTH-1:0]             tag_i,
    output logic                             out_valid_o,
    input  logic                             out_ready_i,
    output logic [DATA_WIDTH-1:0]            rd_data_o,
    output logic [TAG_WIDTH-1:0]             tag_o,
    output logic                             zero_o,
    output logic                             parity_o,
    output logic [$clog2(PIPE_DEPTH+1)-1:0]  occupancy_o
);

    localparam int OCC_W = $clog2(PIPE_DEPTH + 1);
    localparam int LAST  = PIPE_DEPTH - 1;

    logic [PIPE_DEPTH-1:0] v_q;
    logic [PIPE_DEPTH-1:0] adv;
    logic [DATA_WIDTH-1:0] data_q [PIPE_DEPTH];
    logic [TAG_WIDTH-1:0]  tag_q  [PIPE_DEPTH];
    logic [PIPE_DEPTH-1:0] zero_q;
    logic [PIPE_DEPTH-1:0] par_q;
    logic [DATA_WIDTH-1:0] result;

    // Stage k may move when any stage from k to the end has a hole, or the
    // consumer takes the head; one running OR keeps this free of self-loops.
    always_comb begin
        logic chain;
        adv   = '0;
        chain = out_ready_i;
        for (int k = LAST; k >= 0; k--) begin
            chain  = chain || !v_q[k];
            adv[k] = chain;
        end
    end

    always_comb begin
        result = '0;
        case (op_i)
            3'd0:    result = rs1_data_i & rs2_data_i;
            3'd1:    result = rs1_data_i | rs2_data_i;
            3'd2:    result = rs1_data_i ^ rs2_data_i;
            3'd3:    result = ~rs1_data_i;
            3'd4:    result = ~(rs1_data_i & rs2_data_i);
            3'd5:    result = ~(rs1_data_i | rs2_data_i);
            3'd6:    result = ~(rs1_data_i ^ rs2_data_i);
            default: result = rs1_data_i;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            v_q    <= '0;
            zero_q <= '0;
            par_q  <= '0;
            for (int k = 0; k < PIPE_DEPTH; k++) begin
                data_q[k] <= '0;
                tag_q[k]  <= '0;
            end
        end else begin
            if (adv[0]) begin
                v_q[0] <= in_valid_i;
                if (in_valid_i) begin
                    data_q[0] <= result;
                    tag_q[0]  <= tag_i;
                    zero_q[0] <= (result == '0);
                    par_q[0]  <= ^result;
                end
            end
            // Payload only moves with a valid bit so an emptied head keeps its last value.
            for (int k = 1; k < PIPE_DEPTH; k++) begin
                if (adv[k]) begin
                    v_q[k] <= v_q[k-1];
                    if (v_q[k-1]) begin
                        data_q[k] <= data_q[k-1];
                        tag_q[k]  <= tag_q[k-1];
                        zero_q[k] <= zero_q[k-1];
                        par_q[k]  <= par_q[k-1];
                    end
                end
            end
        end
    end

    always_comb begin
        occupancy_o = '0;
        for (int k = 0; k < PIPE_DEPTH; k++) begin
            occupancy_o = occupancy_o + OCC_W'(v_q[k]);
        end
    end

    assign in_ready_o  = adv[0];
    assign out_valid_o = v_q[LAST];
    assign rd_data_o   = data_q[LAST];
    assign tag_o       = tag_q[LAST];
    assign zero_o      = zero_q[LAST];
    assign parity_o    = par_q[LAST];

endmodule

// File: tb/tb_alu_gate_pipe.sv
// tb/tb_alu_gate_pipe.sv - scoreboard bench over depths 2 (directed), 1, 3, 4
module tb_alu_gate_pipe;

    localparam int N = 4;

    typedef struct {
        int          inst;
        logic [31:0] d;
        logic [4:0]  t;
        logic        z;
        logic        p;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid  [N];
    logic        in_ready  [N];
    logic [2:0]  op        [N];
    logic [31:0] rs1       [N];
    logic [31:0] rs2       [N];
    logic [4:0]  tag       [N];
    logic        out_valid [N];
    logic        out_ready [N];
    logic [31:0] rd_data   [N];
    logic [4:0]  tag_out   [N];
    logic        zero      [N];
    logic        parity    [N];
    logic [2:0]  occ       [N];

    exp_t sb[$];
    int   acc  [N];
    int   emit [N];
    logic took [N];
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        localparam int D  = (g == 0) ? 2 : (g == 1) ? 1 : (g == 2) ? 3 : 4;
        localparam int OW = $clog2(D + 1);
        logic [OW-1:0] occ_w;
        alu_gate_pipe #(.DATA_WIDTH(32), .PIPE_DEPTH(D), .TAG_WIDTH(5)) u_dut (
            .clk_i       (clk),
            .rst_i       (rst),
            .in_valid_i  (in_valid[g]),
            .in_ready_o  (in_ready[g]),
            .op_i        (op[g]),
            .rs1_data_i  (rs1[g]),
            .rs2_data_i  (rs2[g]),
            .tag_i       (tag[g]),
            .out_valid_o (out_valid[g]),
            .out_ready_i (out_ready[g]),
            .rd_data_o   (rd_data[g]),
            .tag_o       (tag_out[g]),
            .zero_o      (zero[g]),
            .parity_o    (parity[g]),
            .occupancy_o (occ_w)
        );
        assign occ[g] = 3'(occ_w);
    end

    function automatic logic [31:0] gold(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        case (o)
            3'd0: return a & b;
            3'd1: return a | b;
            3'd2: return a ^ b;
            3'd3: return ~a;
            3'd4: return ~(a & b);
            3'd5: return ~(a | b);
            3'd6: return ~(a ^ b);
            default: return a;
        endcase
    endfunction

    // Runs at the falling edge: retire head transfers first, then record new accepts.
    task automatic monitor();
        exp_t e;
        int   idx;
        if (rst) begin
            sb.delete();
            for (int i = 0; i < N; i++) begin
                acc[i] = 0; emit[i] = 0; took[i] = 1'b0;
            end
            return;
        end
        for (int i = 0; i < N; i++) begin
            vectors++;
            if (occ[i] !== 3'(acc[i] - emit[i])) begin
                miscompares++;
                $display("FAIL occupancy inst%0d got %0d want %0d", i, occ[i], acc[i] - emit[i]);
            end
            took[i] = 1'b0;
            if (out_valid[i] && out_ready[i]) begin
                idx = -1;
                for (int j = 0; j < sb.size(); j++) begin
                    if (sb[j].inst == i) begin
                        idx = j;
                        break;
                    end
                end
                vectors++;
                if (idx < 0) begin
                    miscompares++;
                    $display("FAIL sb_unexpected inst%0d got data %h tag %0d want no output", i, rd_data[i], tag_out[i]);
                end else begin
                    e = sb[idx];
                    sb.delete(idx);
                    if ({rd_data[i], tag_out[i], zero[i], parity[i]} !== {e.d, e.t, e.z, e.p}) begin
                        miscompares++;
                        $display("FAIL sb_result inst%0d got %h/%0d/z%b/p%b want %h/%0d/z%b/p%b", i,
                                 rd_data[i], tag_out[i], zero[i], parity[i], e.d, e.t, e.z, e.p);
                    end
                end
                emit[i]++;
            end
            if (in_valid[i] && in_ready[i]) begin
                e.inst = i;
                e.d    = gold(op[i], rs1[i], rs2[i]);
                e.t    = tag[i];
                e.z    = (e.d == 32'd0);
                e.p    = ^e.d;
                sb.push_back(e);
                acc[i]++;
                took[i] = 1'b1;
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int i, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input logic [4:0] t);
        in_valid[i] = 1'b1;
        op[i]       = o;
        rs1[i]      = a;
        rs2[i]      = b;
        tag[i]      = t;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        for (int i = 0; i < N; i++) begin
            vectors++;
            if ({in_ready[i], out_valid[i], occ[i], rd_data[i], tag_out[i], zero[i], parity[i]} !==
                {1'b1, 1'b0, 3'd0, 32'd0, 5'd0, 1'b0, 1'b0}) begin
                miscompares++;
                $display("FAIL reset_state inst%0d got rdy%b vld%b occ%0d d%h t%0d z%b p%b want rdy1 vld0 occ0 all-zero",
                         i, in_ready[i], out_valid[i], occ[i], rd_data[i], tag_out[i], zero[i], parity[i]);
            end
        end
    endtask

    task automatic test_ops_sweep();
        logic [31:0] exp_tab [8];
        exp_tab = '{32'h00F0000F, 32'hFFF00FFF, 32'hFF000FF0, 32'h0F0FFF00,
                    32'hFF0FFFF0, 32'h000FF000, 32'h00FFF00F, 32'hF0F000FF};
        out_ready[0] = 1'b1;
        for (int j = 0; j < 10; j++) begin
            if (j < 8) drive(0, 3'(j), 32'hF0F000FF, 32'h0FF00F0F, 5'(j + 1));
            else       in_valid[0] = 1'b0;
            step();
            vectors++;
            if (j == 0 || j == 9) begin
                if (out_valid[0] !== 1'b0) begin
                    miscompares++;
                    $display("FAIL sweep_latency step%0d got valid %b want 0", j, out_valid[0]);
                end
            end else if ({out_valid[0], rd_data[0], tag_out[0]} !== {1'b1, exp_tab[j-1], 5'(j)}) begin
                miscompares++;
                $display("FAIL sweep_op%0d got v%b %h tag %0d want v1 %h tag %0d", j - 1,
                         out_valid[0], rd_data[0], tag_out[0], exp_tab[j-1], j);
            end
        end
    endtask

    task automatic test_flags();
        drive(0, 3'd0, 32'hAAAAAAAA, 32'h55555555, 5'd3);
        step();
        drive(0, 3'd7, 32'h00000007, 32'hDEADBEEF, 5'd4);
        step();
        vectors++;
        if ({out_valid[0], rd_data[0], zero[0], parity[0]} !== {1'b1, 32'd0, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL flags_and got v%b %h z%b p%b want v1 00000000 z1 p0", out_valid[0], rd_data[0], zero[0], parity[0]);
        end
        in_valid[0] = 1'b0;
        step();
        vectors++;
        if ({out_valid[0], rd_data[0], zero[0], parity[0]} !== {1'b1, 32'd7, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL flags_pass got v%b %h z%b p%b want v1 00000007 z0 p1", out_valid[0], rd_data[0], zero[0], parity[0]);
        end
        step();
    endtask

    task automatic test_backpressure();
        int          a0, e0;
        logic [4:0]  t;
        logic [38:0] held;
        a0 = acc[0];
        e0 = emit[0];
        t  = 5'd10;
        out_ready[0] = 1'b0;
        drive(0, 3'd2, $urandom, $urandom, t);
        for (int c = 0; c < 6; c++) begin
            step();
            if (took[0]) begin
                t = t + 5'd1;
                drive(0, 3'($urandom_range(0, 7)), $urandom, $urandom, t);
            end
            if (c == 1) held = {rd_data[0], tag_out[0], zero[0], parity[0]};
            if (c >= 2) begin
                vectors++;
                if ({rd_data[0], tag_out[0], zero[0], parity[0]} !== held) begin
                    miscompares++;
                    $display("FAIL stall_stable cycle%0d got %h want %h", c, {rd_data[0], tag_out[0], zero[0], parity[0]}, held);
                end
            end
        end
        vectors++;
        if ({acc[0] - a0, in_ready[0], occ[0], out_valid[0]} !== {32'd2, 1'b0, 3'd2, 1'b1}) begin
            miscompares++;
            $display("FAIL full_state got acc %0d rdy%b occ%0d vld%b want acc 2 rdy0 occ2 vld1",
                     acc[0] - a0, in_ready[0], occ[0], out_valid[0]);
        end
        out_ready[0] = 1'b1;
        step();
        vectors++;
        if ({acc[0] - a0, emit[0] - e0, occ[0]} !== {32'd3, 32'd1, 3'd2}) begin
            miscompares++;
            $display("FAIL full_with_ready got acc %0d emit %0d occ%0d want acc 3 emit 1 occ2", acc[0] - a0, emit[0] - e0, occ[0]);
        end
        in_valid[0] = 1'b0;
        step();
        step();
        step();
        vectors++;
        if ({emit[0] - e0, occ[0]} !== {32'd3, 3'd0}) begin
            miscompares++;
            $display("FAIL drain got emit %0d occ%0d want emit 3 occ0", emit[0] - e0, occ[0]);
        end
    endtask

    task automatic test_reset_mid();
        int seen;
        out_ready[0] = 1'b0;
        drive(0, 3'd1, 32'h12345678, 32'h0F0F0F0F, 5'd20);
        step();
        drive(0, 3'd4, 32'hFFFF0000, 32'hFF00FF00, 5'd21);
        step();
        vectors++;
        if (occ[0] !== 3'd2) begin
            miscompares++;
            $display("FAIL mid_prefill got occ%0d want occ2", occ[0]);
        end
        rst = 1'b1;
        out_ready[0] = 1'b1;
        drive(0, 3'd7, 32'hCAFEF00D, 32'h0, 5'd22);
        step();
        rst = 1'b0;
        in_valid[0] = 1'b0;
        vectors++;
        if ({out_valid[0], occ[0], rd_data[0]} !== {1'b0, 3'd0, 32'd0}) begin
            miscompares++;
            $display("FAIL mid_reset got vld%b occ%0d d%h want vld0 occ0 d00000000", out_valid[0], occ[0], rd_data[0]);
        end
        seen = 0;
        for (int c = 0; c < 4; c++) begin
            step();
            if (out_valid[0]) seen++;
        end
        vectors++;
        if (seen != 0) begin
            miscompares++;
            $display("FAIL mid_stale got %0d outputs want 0", seen);
        end
    endtask

    task automatic test_soak();
        for (int cyc = 0; cyc < 5000; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if (!(in_valid[i] && !took[i])) begin
                    in_valid[i] = ($urandom_range(0, 3) != 0);
                    op[i]       = 3'($urandom_range(0, 7));
                    rs1[i]      = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
                    rs2[i]      = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
                    tag[i]      = 5'($urandom_range(0, 31));
                end
                out_ready[i] = ($urandom_range(0, 3) != 0);
            end
            step();
        end
        for (int i = 0; i < N; i++) begin
            vectors++;
            if (32'(occ[i]) !== 32'(acc[i] - emit[i])) begin
                miscompares++;
                $display("FAIL soak_balance inst%0d got occ %0d want %0d", i, occ[i], acc[i] - emit[i]);
            end
            in_valid[i]  = 1'b0;
            out_ready[i] = 1'b1;
        end
        for (int c = 0; c < 8; c++) step();
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL soak_leftover got %0d pending want 0", sb.size());
        end
    endtask

    initial begin
        rst = 1'b1;
        for (int i = 0; i < N; i++) begin
            in_valid[i]  = 1'b0;
            out_ready[i] = 1'b1;
            op[i]        = 3'd0;
            rs1[i]       = 32'd0;
            rs2[i]       = 32'd0;
            tag[i]       = 5'd0;
            acc[i]       = 0;
            emit[i]      = 0;
            took[i]      = 1'b0;
        end
        test_reset();
        test_ops_sweep();
        test_flags();
        test_backpressure();
        test_reset_mid();
        test_soak();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
